// File: rtl/tdp_ram_pkg.sv
// rtl/tdp_ram_pkg.sv - shared constants and byte-merge helper for tdp_ram_pipe
package tdp_ram_pkg;

  // Same-port read-during-write modes
  localparam int RD_FIRST   = 0;
  localparam int WR_FIRST   = 1;

  localparam int COLL_CNT_W = 16;

  // Widest word the merge helper handles; callers size-cast in and out
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  // Replace the bytes of old_word selected by be with the bytes of new_word
  function automatic logic [MAX_DATA_W-1:0] merge_bytes(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tdp_ram_out_stage.sv
// rtl/tdp_ram_out_stage.sv - per-port read data/valid pipeline (1 or 2 stages)
module tdp_ram_out_stage #(
  parameter int DATA_W  = 8,
  parameter int OUT_REG = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rd_en_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o
);

  logic [DATA_W-1:0] s1_data_q;
  logic              s1_valid_q;

  // First stage: capture the array read; data only moves on a valid access
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= rd_en_i;
      if (rd_en_i) s1_data_q <= rd_data_i;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [DATA_W-1:0] s2_data_q;
      logic              s2_valid_q;

      // Optional output register: delays data and valid by one more cycle
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          s2_data_q  <= '0;
          s2_valid_q <= 1'b0;
        end else begin
          s2_valid_q <= s1_valid_q;
          if (s1_valid_q) s2_data_q <= s1_data_q;
        end
      end

      assign rdata_o  = s2_data_q;
      assign rvalid_o = s2_valid_q;
    end else begin : g_noreg
      assign rdata_o  = s1_data_q;
      assign rvalid_o = s1_valid_q;
    end
  endgenerate

endmodule

// File: rtl/tdp_ram_pipe.sv
// rtl/tdp_ram_pipe.sv - true dual-port RAM with byte enables, collision counter; optional TDP_RAM_PIPE_RAM_CLEAR_EN power-up clear
module tdp_ram_pipe
  import tdp_ram_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 6,
  parameter int RD_MODE = RD_FIRST,
  parameter int OUT_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [DATA_W/8-1:0]   be_a,
  input  logic [ADDR_W-1:0]     addr_a,
  input  logic [DATA_W-1:0]     wdata_a,
  output logic [DATA_W-1:0]     rdata_a,
  output logic                  rvalid_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [DATA_W/8-1:0]   be_b,
  input  logic [ADDR_W-1:0]     addr_b,
  input  logic [DATA_W-1:0]     wdata_b,
  output logic [DATA_W-1:0]     rdata_b,
  output logic                  rvalid_b,
  output logic                  coll,
  output logic [COLL_CNT_W-1:0] coll_cnt,
  input  logic                  coll_clr,
  output logic                  init_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              act_a, act_b, wr_a, wr_b, same_addr, coll_now;
  logic [DATA_W-1:0] old_a, old_b, new_a, base_b, new_b, own_b, rd_a, rd_b;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

`ifdef TDP_RAM_PIPE_RAM_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              init_done_q, init_done_d;

  // Sweep counter advances once per cycle until the last address is written
  always_comb begin
    clr_addr_d  = clr_addr_q;
    init_done_d = init_done_q;
    if (!init_done_q) begin
      clr_addr_d = clr_addr_q + ADDR_W'(1);
      if (clr_addr_q == ADDR_W'(DEPTH - 1)) init_done_d = 1'b1;
    end
  end

  // Reset restarts the sweep from address 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      clr_addr_q  <= clr_addr_d;
      init_done_q <= init_done_d;
    end
  end

  assign init_done = init_done_q;
  assign clr_we    = ~init_done_q;
  assign clr_addr  = clr_addr_q;
`else
  assign init_done = 1'b1;
  assign clr_we    = 1'b0;
  assign clr_addr  = '0;
`endif

  // Accesses are masked until the array is usable
  assign act_a     = en_a & init_done;
  assign act_b     = en_b & init_done;
  assign same_addr = (addr_a == addr_b);
  assign wr_a      = act_a & we_a & (|be_a);
  assign coll_now  = wr_a & act_b & we_b & same_addr & (|(be_a & be_b));
  assign wr_b      = act_b & we_b & (|be_b) & ~coll_now;

  assign old_a  = mem[addr_a];
  assign old_b  = mem[addr_b];
  assign new_a  = DATA_W'(merge_bytes(MAX_DATA_W'(old_a), MAX_DATA_W'(wdata_a), MAX_BE_W'(be_a)));
  assign own_b  = DATA_W'(merge_bytes(MAX_DATA_W'(old_b), MAX_DATA_W'(wdata_b), MAX_BE_W'(be_b)));
  // Same-address disjoint-byte writes: B lands on top of A's merged word so both stick
  assign base_b = (wr_a & same_addr) ? new_a : old_b;
  assign new_b  = DATA_W'(merge_bytes(MAX_DATA_W'(base_b), MAX_DATA_W'(wdata_b), MAX_BE_W'(be_b)));

  // Write-first returns only the port's own merged word; cross-port always sees old data
  assign rd_a = ((RD_MODE == WR_FIRST) && wr_a) ? new_a : old_a;
  assign rd_b = ((RD_MODE == WR_FIRST) && wr_b) ? own_b : old_b;

  // Array update: clear sweep, then port A, then port B (B already folds in A)
  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_addr] <= '0;
    if (wr_a)   mem[addr_a]   <= new_a;
    if (wr_b)   mem[addr_b]   <= new_b;
  end

  logic                  coll_q;
  logic [COLL_CNT_W-1:0] coll_cnt_q, coll_cnt_d;

  // Saturating collision count; clear has priority over an increment
  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (coll_clr) begin
      coll_cnt_d = '0;
    end else if (coll_now && (coll_cnt_q != {COLL_CNT_W{1'b1}})) begin
      coll_cnt_d = coll_cnt_q + COLL_CNT_W'(1);
    end
  end

  // Collision pulse and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_q     <= 1'b0;
      coll_cnt_q <= '0;
    end else begin
      coll_q     <= coll_now;
      coll_cnt_q <= coll_cnt_d;
    end
  end

  assign coll     = coll_q;
  assign coll_cnt = coll_cnt_q;

  tdp_ram_out_stage #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_out_a (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .rd_en_i   (act_a),
    .rd_data_i (rd_a),
    .rdata_o   (rdata_a),
    .rvalid_o  (rvalid_a)
  );

  tdp_ram_out_stage #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_out_b (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .rd_en_i   (act_b),
    .rd_data_i (rd_b),
    .rdata_o   (rdata_b),
    .rvalid_o  (rvalid_b)
  );

endmodule
